// File: rtl/cs_frame_pkg.sv
// rtl/cs_frame_pkg.sv - shared types for the chip-select frame generator
// Purpose: frame phase state encoding shared by the frame generator and its bench.
// Ports: none (package).
package cs_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACTIVE,
    HOLD,
    GAP
  } cs_state_t;

endpackage

// File: rtl/cs_phase_counter.sv
// rtl/cs_phase_counter.sv - loadable down-counter timing one frame phase
// Purpose: counts down from a loaded value and holds at zero; zero marks the last
//          cycle of the current phase.
// Ports:
//   clk       in   1          system clock
//   rst       in   1          synchronous, active-high reset
//   load      in   1          load load_val this cycle (has priority over counting)
//   load_val  in   CNT_WIDTH  value to load (phase length minus one)
//   zero      out  1          count is zero
module cs_phase_counter #(
  parameter int CNT_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  output logic                 zero
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_ONE;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/cs_frame_generator.sv
// rtl/cs_frame_generator.sv - multi-channel SPI chip-select / frame generator
// Purpose: a rising edge on start launches one frame (setup, active, hold) on the
//          selected channel. Optional macro CS_GAP_EN adds an enforced idle gap
//          of GAP_CYC cycles after each frame.
// Ports:
//   clk        in   1               system clock
//   rst        in   1               synchronous, active-high reset
//   start      in   1               frame request, rising edge acted on
//   sel        in   clog2(NUM_CS)   target channel, sampled on the start edge
//   frame_len  in   CNT_WIDTH       active-phase length, sampled on the start edge
//   cs         out  NUM_CS          one-hot chip selects, active-high
//   sclk_en    out  1               high during the active phase only
//   busy       out  1               high from launch until a new edge is accepted
//   done       out  1               one-cycle pulse at frame end
module cs_frame_generator
  import cs_frame_pkg::*;
#(
  parameter int NUM_CS    = 4,
  parameter int CNT_WIDTH = 6,
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC  = 1,
  parameter int GAP_CYC   = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] sel,
  input  logic [CNT_WIDTH-1:0]                        frame_len,
  output logic [NUM_CS-1:0]                           cs,
  output logic                                        sclk_en,
  output logic                                        busy,
  output logic                                        done
);

  localparam int SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] SETUP_LOAD = CNT_WIDTH'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] HOLD_LOAD  = CNT_WIDTH'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
  localparam logic [SEL_W:0]       NUM_CS_V   = (SEL_W + 1)'(NUM_CS);

  cs_state_t            state, state_d;
  logic                 start_q;
  logic                 start_edge;
  logic                 degenerate;
  logic                 latch;
  logic                 frame_end;
  logic                 done_d;
  logic                 done_q;
  logic                 cnt_load;
  logic                 cnt_zero;
  logic [CNT_WIDTH-1:0] cnt_load_val;
  logic [CNT_WIDTH-1:0] len_q;
  logic [SEL_W-1:0]     sel_q;

`ifdef CS_GAP_EN
  localparam logic [CNT_WIDTH-1:0] GAP_LOAD = CNT_WIDTH'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
`else
  // GAP_CYC has no effect when the post-frame gap is not built in.
  logic unused_gap_cyc;
  assign unused_gap_cyc = (GAP_CYC != 0);
`endif

  // start_q resets high so a start held through reset release is not an edge.
  assign start_edge = start & ~start_q;
  assign degenerate = (frame_len == '0) || ({1'b0, sel} >= NUM_CS_V);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      start_q <= 1'b1;
      done_q  <= 1'b0;
      sel_q   <= '0;
      len_q   <= '0;
    end else begin
      state   <= state_d;
      start_q <= start;
      done_q  <= done_d;
      if (latch) begin
        sel_q <= sel;
        len_q <= frame_len;
      end
    end
  end

  cs_phase_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_phase_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    latch        = 1'b0;
    frame_end    = 1'b0;
    done_d       = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          if (degenerate) begin
            // Nothing to drive: report completion on the next cycle, stay idle.
            done_d = 1'b1;
          end else begin
            latch    = 1'b1;
            cnt_load = 1'b1;
            if (SETUP_CYC > 0) begin
              state_d      = SETUP;
              cnt_load_val = SETUP_LOAD;
            end else begin
              state_d      = ACTIVE;
              cnt_load_val = frame_len - CNT_ONE;
            end
          end
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          state_d      = ACTIVE;
          cnt_load     = 1'b1;
          cnt_load_val = len_q - CNT_ONE;
        end
      end
      ACTIVE: begin
        if (cnt_zero) begin
          if (HOLD_CYC > 0) begin
            state_d      = HOLD;
            cnt_load     = 1'b1;
            cnt_load_val = HOLD_LOAD;
          end else begin
            frame_end = 1'b1;
          end
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          frame_end = 1'b1;
        end
      end
      GAP: begin
        if (cnt_zero) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // done is registered, so it lands on the first cycle with cs low.
    if (frame_end) begin
      done_d = 1'b1;
`ifdef CS_GAP_EN
      if (GAP_CYC > 0) begin
        state_d      = GAP;
        cnt_load     = 1'b1;
        cnt_load_val = GAP_LOAD;
      end else begin
        state_d = IDLE;
      end
`else
      state_d = IDLE;
`endif
    end
  end

  assign cs      = (state == SETUP || state == ACTIVE || state == HOLD) ?
                   (NUM_CS'(1) << sel_q) : '0;
  assign sclk_en = (state == ACTIVE);
  assign busy    = (state != IDLE);
  assign done    = done_q;

endmodule
